// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Purpose:
//   8N1 UART receiver using 16x oversampling. The serial line goes through a
//   two-flop synchronizer. A start bit is confirmed at its mid-point, and then
//   each data bit and the stop bit are sampled one bit period apart. A good
//   stop bit updates the data output and produces a one-clock valid pulse. A
//   bad stop bit produces a one-clock frame_err pulse instead, and the
//   receiver then waits for the line to return high before it looks for the
//   next frame.
//
// Parameters:
//   CLK      - system clock frequency in Hz
//   BAUDRATE - serial bit rate in bit/s
//
// Ports:
//   clk       in   1  rising-edge system clock
//   rst       in   1  asynchronous active-low reset
//   rx        in   1  asynchronous serial input, idles high
//   data      out  8  last correctly received byte
//   valid     out  1  one-clock pulse when data is updated
//   frame_err out  1  one-clock pulse on a bad stop bit
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK      = 27000000,
    parameter int BAUDRATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int DIV = CLK / (BAUDRATE * 16);
    // A divider of 1 would give a zero-width counter, so keep at least 1 bit.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic          rxMeta_q, rxSync_q;
    logic [CW-1:0] tickCnt_q, tickCnt_d;
    logic [3:0]    sampleCnt_q, sampleCnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frameErr_q, frameErr_d;
    logic          rxS;
    logic          tick;

    assign rxS       = rxSync_q;
    assign tick      = (tickCnt_q == TICK_MAX);
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frameErr_q;

    // Two-flop synchronizer. Both flops reset high so that coming out of
    // reset does not look like a falling edge on the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // State register for the FSM and all of its datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            sampleCnt_q <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            sampleCnt_q <= sampleCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    // Next-state logic. The tick counter free-runs, and the sample counter
    // advances once per tick and wraps 15->0 by itself. Both counters are
    // cleared when a start edge is seen, so the sample at count 7 lands in
    // the middle of the start bit and the samples at count 15 land in the
    // middle of every following bit.
    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tick ? '0 : tickCnt_q + 1'b1;
        sampleCnt_d = tick ? sampleCnt_q + 4'd1 : sampleCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frameErr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxS) begin
                    state_d     = START;
                    tickCnt_d   = '0;
                    sampleCnt_d = '0;
                end
            end

            START: begin
                if (tick && sampleCnt_q == 4'd7) begin
                    if (!rxS) begin
                        state_d     = DATA;
                        sampleCnt_d = '0;
                        bitIdx_d    = '0;
                    end else begin
                        // The line went high again before mid-bit, so this
                        // was a glitch and not a start bit.
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (tick && sampleCnt_q == 4'd15) begin
                    shift_d  = {rxS, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                if (tick && sampleCnt_q == 4'd15) begin
                    if (rxS) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                // A held-low line (break) must not restart framing.
                if (rxS) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx at the default parameters (DIV = 14, bit
// period = 224 clk). A table of single frames is applied in a loop, followed
// by hand-written sequences for back-to-back frames, glitch rejection, a
// framing error with a held-low line, and a reset that aborts a frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int BIT = 224;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [7:0] txByte;
        logic       stopBit;
        int         period;
        int         expValid;
        logic [7:0] expData;
        int         expErr;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] rxQ[$];
    int         errCount    = 0;
    int         badCycles   = 0;
    int         cycleCount  = 0;
    int         validCycle  = 0;
    int         startCycle  = 0;
    logic       prevValid   = 1'b0;
    logic       prevErr     = 1'b0;
    int         checkCount  = 0;
    int         passCount   = 0;
    int         errBase;

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Output monitor, sampled on the falling edge, away from the active edge.
    // It records each received byte, counts framing errors and flags any
    // pulse that is wider than one clock or that coincides with the other.
    always @(negedge clk) begin
        if (valid) begin
            rxQ.push_back(data);
            validCycle <= cycleCount;
        end
        if (frame_err) errCount <= errCount + 1;
        if ((valid && frame_err) || (valid && prevValid) || (frame_err && prevErr))
            badCycles <= badCycles + 1;
        prevValid <= valid;
        prevErr   <= frame_err;
    end

    task automatic clkWait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one 8N1 frame, LSB first, with a chosen stop bit level and bit
    // period. The line is left at the stop bit level afterwards.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int period);
        rx         = 1'b0;
        startCycle = cycleCount;
        clkWait(period);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clkWait(period);
        end
        rx = stopBit;
        clkWait(period);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 224, 1, 8'hA5, 0};
        vecs[1] = '{8'hC3, 1'b1, 220, 1, 8'hC3, 0};
        vecs[2] = '{8'hC3, 1'b1, 228, 1, 8'hC3, 0};
        vecs[3] = '{8'h00, 1'b1, 224, 1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, 224, 1, 8'hFF, 0};
        vecs[5] = '{8'h55, 1'b1, 224, 1, 8'h55, 0};

        rx  = 1'b1;
        rst = 1'b0;
        clkWait(4);
        checkOutput("reset data", data, 8'h00);
        checkOutput("reset valid", valid, 0);
        checkOutput("reset frame_err", frame_err, 0);
        rst = 1'b1;
        clkWait(20);

        // Single frames, including +/-2% transmitter bit periods.
        for (int i = 0; i < 6; i++) begin
            rxQ.delete();
            errBase = errCount;
            applyStimulus(vecs[i].txByte, vecs[i].stopBit, vecs[i].period);
            clkWait(2 * BIT);
            checkOutput($sformatf("row%0d valid count", i), rxQ.size(), vecs[i].expValid);
            checkOutput($sformatf("row%0d data", i), data, vecs[i].expData);
            checkOutput($sformatf("row%0d frame_err count", i), errCount - errBase, vecs[i].expErr);
            if (i == 0) begin
                if (validCycle - startCycle < 2116 || validCycle - startCycle > 2144)
                    checkOutput("row0 latency in 2130+/-14", validCycle - startCycle, 2130);
                else
                    checkOutput("row0 latency in 2130+/-14", 2130, 2130 + (validCycle - startCycle) * 0);
            end
        end

        // Back-to-back frames with no idle gap after the stop bit.
        rxQ.delete();
        errBase = errCount;
        applyStimulus(8'h00, 1'b1, BIT);
        applyStimulus(8'hFF, 1'b1, BIT);
        applyStimulus(8'h55, 1'b1, BIT);
        clkWait(2 * BIT);
        checkOutput("b2b valid count", rxQ.size(), 3);
        if (rxQ.size() == 3) begin
            checkOutput("b2b byte0", rxQ[0], 8'h00);
            checkOutput("b2b byte1", rxQ[1], 8'hFF);
            checkOutput("b2b byte2", rxQ[2], 8'h55);
        end
        checkOutput("b2b frame_err count", errCount - errBase, 0);

        // A 50 clk low glitch is rejected at the start-bit mid-point.
        rxQ.delete();
        errBase = errCount;
        rx = 1'b0;
        clkWait(50);
        rx = 1'b1;
        clkWait(3 * BIT);
        checkOutput("glitch valid count", rxQ.size(), 0);
        checkOutput("glitch frame_err count", errCount - errBase, 0);
        checkOutput("glitch data held", data, 8'h55);

        // Bad stop bit, then the line is held low for 5 bit periods.
        rxQ.delete();
        errBase = errCount;
        applyStimulus(8'h3C, 1'b0, BIT);
        clkWait(5 * BIT);
        checkOutput("ferr frame_err count", errCount - errBase, 1);
        checkOutput("ferr valid count", rxQ.size(), 0);
        checkOutput("ferr data held", data, 8'h55);
        rx = 1'b1;
        clkWait(2 * BIT);
        checkOutput("ferr no repeat", errCount - errBase, 1);
        applyStimulus(8'h96, 1'b1, BIT);
        clkWait(2 * BIT);
        checkOutput("ferr recovery valid count", rxQ.size(), 1);
        checkOutput("ferr recovery data", data, 8'h96);

        // Reset for 3 clk in the middle of bit 4. Bits 4..7 and the stop bit
        // of the aborted byte are all 1, so the line stays high afterwards.
        rxQ.delete();
        errBase = errCount;
        fork
            applyStimulus(8'hF0, 1'b1, BIT);
            begin
                clkWait(5 * BIT + BIT / 2);
                rst = 1'b0;
                clkWait(3);
                rst = 1'b1;
            end
        join
        clkWait(2 * BIT);
        checkOutput("abort valid count", rxQ.size(), 0);
        checkOutput("abort frame_err count", errCount - errBase, 0);
        checkOutput("abort data cleared", data, 8'h00);
        applyStimulus(8'h81, 1'b1, BIT);
        clkWait(2 * BIT);
        checkOutput("abort recovery valid count", rxQ.size(), 1);
        checkOutput("abort recovery data", data, 8'h81);

        checkOutput("pulse width/exclusivity violations", badCycles, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
